// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, write-back source codes
// and a small register-file write-enable helper.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU_MEM = 2'b00,
        WB_PC4     = 2'b01,
        WB_RSV2    = 2'b10,
        WB_RSV3    = 2'b11
    } wb_sel_t;

    // x0 is hardwired to zero, so a write aimed at it is dropped here
    function automatic logic rf_write_en(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage

// File: rtl/mux2.sv
// 32-bit two-input mux used for the first-level write-back select
// (in0 = ALU result, in1 = memory load data).
module mux2
    import rv32i_pkg::*;
(
    input  logic            sel,
    input  logic [XLEN-1:0] in0,
    input  logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/write_back.sv
// RV32I write-back stage: picks ALU/load/link data for the register file.
// Define WB_FWD_REG_EN to add a registered forwarding copy (o_wb_fwd_*).
module write_back
    import rv32i_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ma_mem_to_reg,
    input  logic [1:0]            i_ma_rw_sel,
    input  logic [XLEN-1:0]       i_ma_result,
    input  logic [XLEN-1:0]       i_ma_read_data,
    input  logic [XLEN-1:0]       i_ma_pc_plus_4,
    input  logic                  i_ma_reg_write,
    input  logic [REG_ADDR_W-1:0] i_ma_rd,
    output logic [XLEN-1:0]       o_wb_data,
    output logic                  o_wb_reg_write,
`ifdef WB_FWD_REG_EN
    output logic [XLEN-1:0]       o_wb_fwd_data,
    output logic [REG_ADDR_W-1:0] o_wb_fwd_rd,
    output logic                  o_wb_fwd_valid,
`endif
    output logic [REG_ADDR_W-1:0] o_wb_rd
);

    logic [XLEN-1:0] alu_mem_data;

    mux2 u_mux2 (
        .sel (i_ma_mem_to_reg),
        .in0 (i_ma_result),
        .in1 (i_ma_read_data),
        .out (alu_mem_data)
    );

    // Reserved select codes drive zero so no code can leak stale or X data
    always_comb begin
        o_wb_data = '0;
        case (wb_sel_t'(i_ma_rw_sel))
            WB_ALU_MEM: o_wb_data = alu_mem_data;
            WB_PC4:     o_wb_data = i_ma_pc_plus_4;
            default:    o_wb_data = '0;
        endcase
    end

    assign o_wb_reg_write = rf_write_en(i_ma_reg_write, i_ma_rd);
    assign o_wb_rd        = i_ma_rd;

`ifdef WB_FWD_REG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_fwd_data  <= '0;
            o_wb_fwd_rd    <= '0;
            o_wb_fwd_valid <= 1'b0;
        end else begin
            o_wb_fwd_data  <= o_wb_data;
            o_wb_fwd_rd    <= o_wb_rd;
            o_wb_fwd_valid <= o_wb_reg_write;
        end
    end
`else
    // Clock and reset stay on the port list so every stage shares one interface
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;
`endif

endmodule

// File: tb/tb_write_back.sv
// Directed testbench for write_back: scoreboard of expected combinational
// results, plus forwarding-register checks when WB_FWD_REG_EN is defined.
module tb_write_back;

    localparam logic [31:0] RES = 32'hAAAA_AAAA;
    localparam logic [31:0] RDD = 32'hBBBB_BBBB;
    localparam logic [31:0] PC4 = 32'hCCCC_CCCC;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ma_mem_to_reg = 1'b0;
    logic [1:0]  i_ma_rw_sel = 2'b00;
    logic [31:0] i_ma_result = RES;
    logic [31:0] i_ma_read_data = RDD;
    logic [31:0] i_ma_pc_plus_4 = PC4;
    logic        i_ma_reg_write = 1'b0;
    logic [4:0]  i_ma_rd = 5'd0;
    logic [31:0] o_wb_data;
    logic        o_wb_reg_write;
    logic [4:0]  o_wb_rd;
`ifdef WB_FWD_REG_EN
    logic [31:0] o_wb_fwd_data;
    logic [4:0]  o_wb_fwd_rd;
    logic        o_wb_fwd_valid;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t scoreboard[$];

    write_back dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_ma_mem_to_reg (i_ma_mem_to_reg),
        .i_ma_rw_sel     (i_ma_rw_sel),
        .i_ma_result     (i_ma_result),
        .i_ma_read_data  (i_ma_read_data),
        .i_ma_pc_plus_4  (i_ma_pc_plus_4),
        .i_ma_reg_write  (i_ma_reg_write),
        .i_ma_rd         (i_ma_rd),
        .o_wb_data       (o_wb_data),
        .o_wb_reg_write  (o_wb_reg_write),
`ifdef WB_FWD_REG_EN
        .o_wb_fwd_data   (o_wb_fwd_data),
        .o_wb_fwd_rd     (o_wb_fwd_rd),
        .o_wb_fwd_valid  (o_wb_fwd_valid),
`endif
        .o_wb_rd         (o_wb_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model written from the select table, independent of the RTL structure
    function automatic logic [31:0] model_data(input logic m2r, input logic [1:0] sel,
                                               input logic [31:0] res, input logic [31:0] rdd,
                                               input logic [31:0] pc4);
        if (sel == 2'b01)  return pc4;
        if (sel[1])        return 32'h0;
        return m2r ? rdd : res;
    endfunction

    // Drive inputs on the falling edge and queue what the outputs must show
    task automatic applyStimulus(input string tag, input logic m2r, input logic [1:0] sel,
                                 input logic [31:0] res, input logic [31:0] rdd,
                                 input logic [31:0] pc4, input logic we, input logic [4:0] rd);
        exp_t e;
        @(negedge i_clk);
        i_ma_mem_to_reg = m2r;
        i_ma_rw_sel     = sel;
        i_ma_result     = res;
        i_ma_read_data  = rdd;
        i_ma_pc_plus_4  = pc4;
        i_ma_reg_write  = we;
        i_ma_rd         = rd;
        e.tag  = tag;
        e.data = model_data(m2r, sel, res, rdd, pc4);
        e.we   = we && (rd != 5'd0);
        e.rd   = rd;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        if (scoreboard.size() == 0) begin
            compare("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = scoreboard.pop_front();
        compare({e.tag, ".data"}, o_wb_data, e.data);
        compare({e.tag, ".we"}, {31'd0, o_wb_reg_write}, {31'd0, e.we});
        compare({e.tag, ".rd"}, {27'd0, o_wb_rd}, {27'd0, e.rd});
    endtask

    initial begin
        $display("[TB] write_back test start");
        repeat (2) @(posedge i_clk);
        i_rst = 1'b0;
`ifdef WB_FWD_REG_EN
        #1;
        compare("fwd_reset_data", o_wb_fwd_data, 32'h0);
        compare("fwd_reset_rd", {27'd0, o_wb_fwd_rd}, 32'h0);
        compare("fwd_reset_valid", {31'd0, o_wb_fwd_valid}, 32'h0);
`endif

        // Full sweep of mem_to_reg x rw_sel with the fixed data patterns
        for (int s = 0; s < 4; s++) begin
            for (int m = 0; m < 2; m++) begin
                applyStimulus($sformatf("sel%0d_m2r%0d", s, m), m[0], s[1:0],
                              RES, RDD, PC4, 1'b1, 5'd3);
                checkOutput();
            end
        end

        applyStimulus("x0_write", 1'b0, 2'b00, RES, RDD, PC4, 1'b1, 5'd0);
        checkOutput();
        applyStimulus("rd5_write", 1'b0, 2'b00, RES, RDD, PC4, 1'b1, 5'd5);
        checkOutput();
        applyStimulus("we_off", 1'b1, 2'b00, RES, RDD, PC4, 1'b0, 5'd31);
        checkOutput();

        for (int k = 0; k < 8; k++) begin
            applyStimulus($sformatf("rand%0d", k), 1'($urandom), 2'($urandom),
                          $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom));
            checkOutput();
        end

`ifdef WB_FWD_REG_EN
        applyStimulus("fwd_cap", 1'b0, 2'b00, RES, RDD, PC4, 1'b1, 5'd7);
        checkOutput();
        @(posedge i_clk);
        #1;
        compare("fwd_cap_data", o_wb_fwd_data, RES);
        compare("fwd_cap_rd", {27'd0, o_wb_fwd_rd}, 32'd7);
        compare("fwd_cap_valid", {31'd0, o_wb_fwd_valid}, 32'd1);

        applyStimulus("fwd_rst", 1'b1, 2'b00, RES, RDD, PC4, 1'b1, 5'd9);
        i_rst = 1'b1;
        checkOutput();
        @(posedge i_clk);
        #1;
        compare("fwd_rst_data", o_wb_fwd_data, 32'h0);
        compare("fwd_rst_rd", {27'd0, o_wb_fwd_rd}, 32'h0);
        compare("fwd_rst_valid", {31'd0, o_wb_fwd_valid}, 32'h0);
        compare("fwd_rst_comb", o_wb_data, RDD);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        compare("fwd_after_rst_data", o_wb_fwd_data, RDD);
        compare("fwd_after_rst_rd", {27'd0, o_wb_fwd_rd}, 32'd9);
`endif

        compare("scoreboard_drained", scoreboard.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
